// File: rtl/aes_pkg.sv
// Shared AES definitions: controller states, key-length and mode encodings,
// and round counts used by the controller, datapath and key expansion.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEYWAIT = 3'd1,
        S_LOAD    = 3'd2,
        S_ROUND   = 3'd3,
        S_FINAL   = 3'd4,
        S_DONE    = 3'd5
    } aes_state_e;

    localparam logic [1:0] KEY_128 = 2'b00;
    localparam logic [1:0] KEY_192 = 2'b01;
    localparam logic [1:0] KEY_256 = 2'b10;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

endpackage

// File: rtl/aes_round_counter.sv
// Round-key index counter: loadable, up/down, synchronous clear,
// with a match flag against a caller-supplied terminal value.
module aes_round_counter #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    input  logic          down_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= down_i ? cnt_q - CW'(1) : cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: AES-128/192/256, encrypt or decrypt per block,
// start/ready in, done/ack out, synchronous abort.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR_128 = NR_AES128,
    parameter int NR_192 = NR_AES192,
    parameter int NR_256 = NR_AES256,
    parameter int CW     = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    key_len_i,
    input  logic          mode_i,
    input  logic          key_ready_i,
    input  logic          abort_i,
    input  logic          out_ack_i,
    output logic          ready_o,
    output logic          load_o,
    output logic          round_o,
    output logic          last_o,
    output logic          done_o,
    output logic          busy_o,
    output logic [CW-1:0] round_idx_o
);

    aes_state_e    state_q, state_d;
    logic [1:0]    klen_q;
    logic          mode_q;
    logic          accept;
    logic [1:0]    klen_eff;
    logic          mode_eff;
    logic [CW-1:0] nr_q;
    logic [CW-1:0] load_val;
    logic [CW-1:0] term;
    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          cnt_clr;
    logic          cnt_load;
    logic          cnt_en;

    // Reserved key length falls back to the AES-128 round count.
    function automatic logic [CW-1:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEY_192: return CW'(NR_192);
            KEY_256: return CW'(NR_256);
            default: return CW'(NR_128);
        endcase
    endfunction

    assign accept = (state_q == S_IDLE) && start_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            klen_q  <= KEY_128;
            mode_q  <= ENC;
        end else begin
            state_q <= state_d;
            if (accept) begin
                klen_q <= key_len_i;
                mode_q <= mode_i;
            end
        end
    end

    // On a direct IDLE->LOAD the captured values are not yet registered.
    assign klen_eff = (state_q == S_IDLE) ? key_len_i : klen_q;
    assign mode_eff = (state_q == S_IDLE) ? mode_i : mode_q;
    assign nr_q     = nr_of(klen_q);
    assign load_val = (mode_eff == DEC) ? nr_of(klen_eff) : '0;
    assign term     = (mode_q == DEC) ? CW'(1) : nr_q - CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (key_ready_i) begin
                        state_d  = S_LOAD;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = S_KEYWAIT;
                    end
                end
            end
            S_KEYWAIT: begin
                if (key_ready_i) begin
                    state_d  = S_LOAD;
                    cnt_load = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                cnt_en  = 1'b1;
            end
            S_ROUND: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
                cnt_clr = 1'b1;
            end
            S_DONE: begin
                if (out_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        if (abort_i && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            cnt_clr  = 1'b1;
            cnt_load = 1'b0;
            cnt_en   = 1'b0;
        end
    end

    aes_round_counter #(
        .CW (CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (load_val),
        .en_i       (cnt_en),
        .down_i     (mode_q == DEC),
        .term_i     (term),
        .cnt_o      (cnt),
        .tc_o       (cnt_tc)
    );

    assign ready_o     = (state_q == S_IDLE);
    assign load_o      = (state_q == S_LOAD);
    assign round_o     = (state_q == S_ROUND);
    assign last_o      = (state_q == S_FINAL);
    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign round_idx_o = (load_o || round_o || last_o) ? cnt : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl: per-cycle sequence checks for
// each key length and mode, key stalls, abort, reset and ack back-pressure.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] klen;
    logic       mode;
    logic       key_ready;
    logic       abort;
    logic       ack;
    logic       ready;
    logic       load;
    logic       round;
    logic       last;
    logic       done;
    logic       busy;
    logic [3:0] idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .key_len_i   (klen),
        .mode_i      (mode),
        .key_ready_i (key_ready),
        .abort_i     (abort),
        .out_ack_i   (ack),
        .ready_o     (ready),
        .load_o      (load),
        .round_o     (round),
        .last_o      (last),
        .done_o      (done),
        .busy_o      (busy),
        .round_idx_o (idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {ready,load,round,last,done,busy}
    task automatic expect_state(input string nm, input logic [5:0] f, input int ei);
        total++;
        if ({ready, load, round, last, done, busy} !== f || idx !== 4'(ei)) begin
            bad++;
            $display("FAIL %s t=%0t flags=%b idx=%0d required flags=%b idx=%0d",
                     nm, $time, {ready, load, round, last, done, busy}, idx, f, ei);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; klen = 2'b00; mode = 1'b0;
        key_ready = 1'b1; abort = 1'b0; ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({ready, load, round, last, done, busy} !== 6'b100000 || idx !== 4'd0) begin
            bad++;
            $display("FAIL reset flags=%b idx=%0d required flags=100000 idx=0",
                     {ready, load, round, last, done, busy}, idx);
        end
    endtask

    // Full block with per-cycle checks. kwait: KEYWAIT cycles;
    // ackwait: DONE cycles with ack low while start pulses.
    task automatic run_block(input string nm, input logic [1:0] kl, input logic md,
                             input int nr, input int kwait, input int ackwait,
                             input bit drop_key);
        int ei;
        key_ready = (kwait == 0);
        ack = (ackwait == 0);
        start = 1'b1; klen = kl; mode = md;
        step();
        start = 1'b0; klen = ~kl; mode = ~md;
        for (int k = 0; k < kwait; k++) begin
            expect_state({nm, "_keywait"}, 6'b000001, 0);
            if (k == kwait - 1) key_ready = 1'b1;
            step();
        end
        ei = md ? nr : 0;
        expect_state({nm, "_load"}, 6'b010001, ei);
        step();
        for (int i = 1; i < nr; i++) begin
            ei = md ? nr - i : i;
            expect_state({nm, "_round"}, 6'b001001, ei);
            if (drop_key && i == 3) key_ready = 1'b0;
            step();
        end
        ei = md ? 0 : nr;
        expect_state({nm, "_final"}, 6'b000101, ei);
        step();
        for (int a = 0; a < ackwait; a++) begin
            expect_state({nm, "_done_hold"}, 6'b000011, 0);
            start = (a % 2 == 0);
            step();
        end
        ack = 1'b1;
        start = 1'b1;
        expect_state({nm, "_done"}, 6'b000011, 0);
        step();
        start = 1'b0; ack = 1'b0; key_ready = 1'b1;
        expect_state({nm, "_idle"}, 6'b100000, 0);
        step();
        expect_state({nm, "_no_accept"}, 6'b100000, 0);
    endtask

    task automatic test_enc128();
        run_block("enc128", 2'b00, 1'b0, 10, 0, 0, 1'b0);
    endtask

    task automatic test_dec256();
        run_block("dec256", 2'b10, 1'b1, 14, 0, 0, 1'b0);
    endtask

    task automatic test_keywait();
        run_block("kw192", 2'b01, 1'b0, 12, 5, 0, 1'b1);
    endtask

    task automatic test_ack_wait();
        run_block("ackwait", 2'b00, 1'b1, 10, 0, 7, 1'b0);
    endtask

    task automatic test_reserved();
        run_block("rsvd", 2'b11, 1'b0, 10, 0, 0, 1'b0);
    endtask

    task automatic check_no_done(input string nm);
        int seen = 0;
        for (int c = 0; c < 16; c++) begin
            if (done !== 1'b0 || ready !== 1'b1) seen++;
            step();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s cycles_not_idle=%0d required 0", nm, seen);
        end
    endtask

    task automatic test_abort();
        key_ready = 1'b1; ack = 1'b1;
        start = 1'b1; klen = 2'b00; mode = 1'b0;
        step();
        start = 1'b0;
        expect_state("abort_load", 6'b010001, 0);
        for (int i = 0; i < 4; i++) step();
        expect_state("abort_r4", 6'b001001, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_state("abort_idle", 6'b100000, 0);
        check_no_done("abort_nodone");
    endtask

    task automatic test_rst_final();
        key_ready = 1'b1; ack = 1'b1;
        start = 1'b1; klen = 2'b01; mode = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        expect_state("rst_final", 6'b000101, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_state("rst_idle", 6'b100000, 0);
        check_no_done("rst_nodone");
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_dec256();
        test_keywait();
        test_abort();
        test_rst_final();
        test_ack_wait();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
